// File: rtl/serial_demux8_if.sv
// Serial-in and read-side signals of the eight-channel serial receiver.
// The bench drives the master modport and the receiver uses the slave modport.
interface serial_demux8_if;
  logic        sen;
  logic        sstart;
  logic        sdata;
  logic [2:0]  rd_sel;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [7:0]  valid;
  logic [7:0]  overrun;
  logic        busy;

  modport master (
    output sen, sstart, sdata, rd_sel, rd_en,
    input  rd_data, valid, overrun, busy
  );

  modport slave (
    input  sen, sstart, sdata, rd_sel, rd_en,
    output rd_data, valid, overrun, busy
  );
endinterface

// File: rtl/serial_demux8.sv
// Bit-serial frame receiver: 3-bit address then 16-bit word, MSB first,
// routed into eight holding registers drained through a select/read handshake.
//   state | meaning
//   IDLE  | waiting for sen & sstart
//   ADDR  | collecting addr[2:0]
//   DATA  | collecting d[15:0]; the 16th bit commits
module serial_demux8 (
  input  logic            clk,
  input  logic            rst_n,
  serial_demux8_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q;
  logic [2:0]  addr_q;
  logic [15:0] shift_q;
  logic [4:0]  count_q;
  logic [15:0] hold_q [8];
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  overrun_q, overrun_d;

  logic [2:0]  addr_d;
  logic [15:0] shift_d;
  logic        start;
  logic        commit;
  logic        rd_hit;

  assign start   = bus.sen & bus.sstart;
  assign addr_d  = (addr_q << 1) | {2'b00, bus.sdata};
  assign shift_d = (shift_q << 1) | {15'd0, bus.sdata};
  // A restart on the final data bit wins over the commit.
  assign commit  = bus.sen && !bus.sstart && (state_q == DATA) && (count_q == 5'd15);
  assign rd_hit  = bus.rd_en & valid_q[bus.rd_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      count_q <= '0;
    end else if (start) begin
      state_q <= ADDR;
      addr_q  <= {2'b00, bus.sdata};
      shift_q <= '0;
      count_q <= 5'd1;
    end else if (bus.sen) begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          addr_q <= addr_d;
          if (count_q == 5'd2) begin
            state_q <= DATA;
            count_q <= 5'd0;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        DATA: begin
          shift_q <= shift_d;
          if (count_q == 5'd15) begin
            state_q <= IDLE;
            count_q <= 5'd0;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (rd_hit) begin
      valid_d[bus.rd_sel]   = 1'b0;
      overrun_d[bus.rd_sel] = 1'b0;
    end
    // A word read on the same edge it is replaced is not an overrun.
    if (commit) begin
      valid_d[addr_q] = 1'b1;
      if (valid_q[addr_q] && !(rd_hit && (bus.rd_sel == addr_q)))
        overrun_d[addr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      overrun_q <= '0;
      for (int i = 0; i < 8; i++) hold_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (commit) hold_q[addr_q] <= shift_d;
    end
  end

  assign bus.rd_data = hold_q[bus.rd_sel];
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_serial_demux8.sv
// Directed self-checking bench for serial_demux8 with hand-computed expectations.
module tb_serial_demux8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   frame_cycles;
  logic frame_busy_ok;

  serial_demux8_if bus ();

  serial_demux8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s_en, input logic s_start, input logic s_data);
    bus.sen    = s_en;
    bus.sstart = s_start;
    bus.sdata  = s_data;
    tick();
  endtask

  // Sends a full frame; optional idle cycle after every bit, optional read of
  // the target channel on the committing edge (checks the old word first).
  task automatic send_frame(input logic [2:0] addr, input logic [15:0] data,
                            input bit gap, input bit collide, input logic [15:0] old_word);
    logic [18:0] bits;
    bits = {addr, data};
    frame_cycles  = 0;
    frame_busy_ok = 1'b1;
    for (int i = 18; i >= 0; i--) begin
      if (collide && i == 0) begin
        bus.rd_sel = addr;
        bus.rd_en  = 1'b1;
        #1;
        chk("collide_old_word", bus.rd_data, old_word);
      end
      drive(1'b1, (i == 18), bits[i]);
      frame_cycles++;
      bus.rd_en = 1'b0;
      if (i != 0) begin
        if (bus.busy !== 1'b1) frame_busy_ok = 1'b0;
        if (gap) begin
          drive(1'b0, 1'b0, 1'b0);
          frame_cycles++;
          if (bus.busy !== 1'b1) frame_busy_ok = 1'b0;
        end
      end
    end
    bus.sen = 1'b0;
  endtask

  task automatic read_ch(input logic [2:0] ch);
    bus.rd_sel = ch;
    bus.rd_en  = 1'b1;
    tick();
    bus.rd_en  = 1'b0;
  endtask

  initial begin
    bus.sen = 1'b0; bus.sstart = 1'b0; bus.sdata = 1'b0;
    bus.rd_sel = 3'd0; bus.rd_en = 1'b0;
    tick(); tick();
    chk("reset_busy", {15'd0, bus.busy}, 16'h0000);
    chk("reset_valid", {8'd0, bus.valid}, 16'h0000);
    chk("reset_rd_data", bus.rd_data, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Bits without sstart are ignored.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
    bus.sen = 1'b0;
    chk("nostart_busy", {15'd0, bus.busy}, 16'h0000);
    chk("nostart_valid", {8'd0, bus.valid}, 16'h0000);

    // Basic frame, continuous sen.
    send_frame(3'd5, 16'hA5C3, 1'b0, 1'b0, 16'h0);
    chk("basic_busy_during", {15'd0, frame_busy_ok}, 16'h0001);
    chk("basic_cycles", frame_cycles[15:0], 16'd19);
    chk("basic_busy_after", {15'd0, bus.busy}, 16'h0000);
    chk("basic_valid", {8'd0, bus.valid}, 16'h0020);
    bus.rd_sel = 3'd5; #1;
    chk("basic_rd_data", bus.rd_data, 16'hA5C3);
    read_ch(3'd5);
    chk("basic_valid_cleared", {8'd0, bus.valid}, 16'h0000);

    // Gapped sen.
    send_frame(3'd0, 16'h8001, 1'b1, 1'b0, 16'h0);
    chk("gap_busy_during", {15'd0, frame_busy_ok}, 16'h0001);
    chk("gap_cycles", frame_cycles[15:0], 16'd37);
    chk("gap_valid", {8'd0, bus.valid}, 16'h0001);
    bus.rd_sel = 3'd0; #1;
    chk("gap_rd_data", bus.rd_data, 16'h8001);
    read_ch(3'd0);

    // Overrun on channel 7, back-to-back frames.
    send_frame(3'd7, 16'h1111, 1'b0, 1'b0, 16'h0);
    chk("ovr_first_overrun", {8'd0, bus.overrun}, 16'h0000);
    send_frame(3'd7, 16'h2222, 1'b0, 1'b0, 16'h0);
    chk("ovr_overrun", {8'd0, bus.overrun}, 16'h0080);
    chk("ovr_valid", {8'd0, bus.valid}, 16'h0080);
    bus.rd_sel = 3'd7; #1;
    chk("ovr_rd_data", bus.rd_data, 16'h2222);
    read_ch(3'd7);
    chk("ovr_valid_cleared", {8'd0, bus.valid}, 16'h0000);
    chk("ovr_overrun_cleared", {8'd0, bus.overrun}, 16'h0000);

    // Read of an empty channel has no effect and shows the stale word.
    read_ch(3'd7);
    chk("empty_read_valid", {8'd0, bus.valid}, 16'h0000);
    chk("empty_read_stale", bus.rd_data, 16'h2222);

    // Collision: commit and read on channel 2 on the same edge.
    send_frame(3'd2, 16'h0F0F, 1'b0, 1'b0, 16'h0);
    chk("coll_setup_valid", {8'd0, bus.valid}, 16'h0004);
    send_frame(3'd2, 16'hBEEF, 1'b0, 1'b1, 16'h0F0F);
    bus.rd_sel = 3'd2; #1;
    chk("coll_new_word", bus.rd_data, 16'hBEEF);
    chk("coll_valid", {8'd0, bus.valid}, 16'h0004);
    chk("coll_overrun", {8'd0, bus.overrun}, 16'h0000);
    read_ch(3'd2);

    // Abort after 8 data bits of a frame for channel 3, then a full frame for channel 1.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1);
    send_frame(3'd1, 16'h00FF, 1'b0, 1'b0, 16'h0);
    chk("abort_valid", {8'd0, bus.valid}, 16'h0002);
    bus.rd_sel = 3'd1; #1;
    chk("abort_rd_data", bus.rd_data, 16'h00FF);
    bus.rd_sel = 3'd3; #1;
    chk("abort_ch3_untouched", bus.rd_data, 16'h0000);
    read_ch(3'd1);

    // Reset mid-frame with valid = 8'h05.
    send_frame(3'd0, 16'h1234, 1'b0, 1'b0, 16'h0);
    send_frame(3'd2, 16'h5678, 1'b0, 1'b0, 16'h0);
    chk("rst_pre_valid", {8'd0, bus.valid}, 16'h0005);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("rst_pre_busy", {15'd0, bus.busy}, 16'h0001);
    bus.rd_sel = 3'd2;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {15'd0, bus.busy}, 16'h0000);
    chk("rst_valid", {8'd0, bus.valid}, 16'h0000);
    chk("rst_overrun", {8'd0, bus.overrun}, 16'h0000);
    chk("rst_rd_data", bus.rd_data, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) drive(1'b1, 1'b0, 1'b1);
    bus.sen = 1'b0;
    chk("post_rst_busy", {15'd0, bus.busy}, 16'h0000);
    chk("post_rst_valid", {8'd0, bus.valid}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
